ex_stage: RTL and testbench

- Execute stage of each core's 5-stage RV32 pipeline; consumes the registered ID/EX controls and operands and produces the registered EX/MEM pipeline register.
- Contains:
  - operand forwarding muxes
  - single-cycle ALU for base and MUL ops
  - 32-iteration restoring divider for DIV/DIVU/REM/REMU, controlled by a 3-state FSM
  - branch condition and target computation
- Raises ex_busy_out toward the hazard unit while a divide is in flight.

---
 rtl/ex_stage_if.sv | 54 +++++
 rtl/ex_stage.sv | 195 +++++++++++++++++++
 tb/tb_ex_stage.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding sources and registered EX/MEM outputs of the execute stage.
// The master drives the ID/EX side; the slave (ex_stage) drives the EX/MEM side.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] ex_pc_plus_4_in;
    logic [XLEN-1:0] ex_read_data1_in;
    logic [XLEN-1:0] ex_read_data2_in;
    logic [XLEN-1:0] ex_immediate_in;
    logic [4:0]      ex_rd_addr_in;
    logic            ex_mem_read_in;
    logic            ex_mem_write_in;
    logic            ex_reg_write_in;
    logic            ex_MemToReg_in;
    logic            ex_ALUSrc_in;
    logic            ex_Branch_in;
    logic [3:0]      ex_ALUCtrl_in;
    logic [31:0]     ex_instruction_in;
    logic [1:0]      forward_a_sel;
    logic [1:0]      forward_b_sel;
    logic [XLEN-1:0] wb_write_data_in;

    logic            ex_busy_out;
    logic [XLEN-1:0] mem_alu_result_out;
    logic [XLEN-1:0] mem_write_data_out;
    logic [4:0]      mem_rd_addr_out;
    logic            mem_mem_read_out;
    logic            mem_mem_write_out;
    logic            mem_reg_write_out;
    logic            mem_MemToReg_out;
    logic            mem_branch_taken_out;
    logic [XLEN-1:0] mem_branch_target_out;
    logic [31:0]     mem_instruction_out;

    modport master (
        output ex_pc_plus_4_in, ex_read_data1_in, ex_read_data2_in, ex_immediate_in,
               ex_rd_addr_in, ex_mem_read_in, ex_mem_write_in, ex_reg_write_in,
               ex_MemToReg_in, ex_ALUSrc_in, ex_Branch_in, ex_ALUCtrl_in,
               ex_instruction_in, forward_a_sel, forward_b_sel, wb_write_data_in,
        input  ex_busy_out, mem_alu_result_out, mem_write_data_out, mem_rd_addr_out,
               mem_mem_read_out, mem_mem_write_out, mem_reg_write_out, mem_MemToReg_out,
               mem_branch_taken_out, mem_branch_target_out, mem_instruction_out
    );

    modport slave (
        input  ex_pc_plus_4_in, ex_read_data1_in, ex_read_data2_in, ex_immediate_in,
               ex_rd_addr_in, ex_mem_read_in, ex_mem_write_in, ex_reg_write_in,
               ex_MemToReg_in, ex_ALUSrc_in, ex_Branch_in, ex_ALUCtrl_in,
               ex_instruction_in, forward_a_sel, forward_b_sel, wb_write_data_in,
        output ex_busy_out, mem_alu_result_out, mem_write_data_out, mem_rd_addr_out,
               mem_mem_read_out, mem_mem_write_out, mem_reg_write_out, mem_MemToReg_out,
               mem_branch_taken_out, mem_branch_target_out, mem_instruction_out
    );
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: forwarding muxes, single-cycle ALU/MUL, iterative restoring
// divider under a 3-state FSM, branch resolution and the EX/MEM pipeline register.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL = 4'h6, OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_MUL = 4'hA, OP_DIV  = 4'hB;
    localparam logic [3:0] OP_DIVU = 4'hC, OP_REM  = 4'hD, OP_REMU = 4'hE;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [4:0]      rd;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            br_taken;
        logic [XLEN-1:0] br_target;
        logic [31:0]     instr;
    } exmem_t;

    localparam exmem_t BUBBLE = '{instr: NOP_INSTR, default: '0};

    state_t          state_q, state_d;
    exmem_t          exmem_q, exmem_d, cur, dv_ctl;
    logic [XLEN-1:0] op_a, op_b_fwd, op_b, alu_res;
    logic            is_div, busy;

    logic [3:0]      dv_op;
    logic [XLEN-1:0] dv_rem, dv_quo, dv_dvs, dv_a, dv_q, dv_r;
    logic            dv_neg_q, dv_neg_r, dv_zero;
    logic [5:0]      dv_cnt;
    logic [XLEN:0]   rem_sh, diff;
    logic            a_neg, b_neg, dv_signed;

    always_comb begin
        case (bus.forward_a_sel)
            2'b01:   op_a = exmem_q.alu_result;
            2'b10:   op_a = bus.wb_write_data_in;
            default: op_a = bus.ex_read_data1_in;
        endcase
        case (bus.forward_b_sel)
            2'b01:   op_b_fwd = exmem_q.alu_result;
            2'b10:   op_b_fwd = bus.wb_write_data_in;
            default: op_b_fwd = bus.ex_read_data2_in;
        endcase
        op_b = bus.ex_ALUSrc_in ? bus.ex_immediate_in : op_b_fwd;
    end

    assign is_div = (bus.ex_ALUCtrl_in >= OP_DIV) && (bus.ex_ALUCtrl_in <= OP_REMU);

    always_comb begin
        alu_res = '0;
        case (bus.ex_ALUCtrl_in)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << op_b[4:0];
            OP_SRL:  alu_res = op_a >> op_b[4:0];
            OP_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_MUL:  alu_res = op_a * op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cur            = BUBBLE;
        cur.alu_result = alu_res;
        cur.write_data = op_b_fwd;
        cur.rd         = bus.ex_rd_addr_in;
        cur.mem_read   = bus.ex_mem_read_in;
        cur.mem_write  = bus.ex_mem_write_in;
        cur.reg_write  = bus.ex_reg_write_in;
        cur.mem_to_reg = bus.ex_MemToReg_in;
        cur.br_taken   = bus.ex_Branch_in & (op_a == op_b_fwd);
        cur.br_target  = bus.ex_pc_plus_4_in - XLEN'(4) + bus.ex_immediate_in;
        cur.instr      = bus.ex_instruction_in;
    end

    // Signs are stripped on acceptance so the iterations only see magnitudes.
    assign dv_signed = (bus.ex_ALUCtrl_in == OP_DIV) || (bus.ex_ALUCtrl_in == OP_REM);
    assign a_neg     = dv_signed & op_a[XLEN-1];
    assign b_neg     = dv_signed & op_b[XLEN-1];

    assign rem_sh = {dv_rem, dv_quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dv_dvs};

    always_comb begin
        dv_q = dv_neg_q ? -dv_quo : dv_quo;
        dv_r = dv_neg_r ? -dv_rem : dv_rem;
        if (dv_zero) begin
            dv_q = '1;
            dv_r = dv_a;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        exmem_d = BUBBLE;
        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    busy    = 1'b1;
                    state_d = S_BUSY;
                end else begin
                    exmem_d = cur;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (dv_cnt == 6'(DIV_ITERS - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d            = S_IDLE;
                exmem_d            = dv_ctl;
                exmem_d.alu_result = (dv_op == OP_DIV || dv_op == OP_DIVU) ? dv_q : dv_r;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            exmem_q  <= BUBBLE;
            dv_ctl   <= BUBBLE;
            dv_op    <= '0;
            dv_rem   <= '0;
            dv_quo   <= '0;
            dv_dvs   <= '0;
            dv_a     <= '0;
            dv_neg_q <= 1'b0;
            dv_neg_r <= 1'b0;
            dv_zero  <= 1'b0;
            dv_cnt   <= '0;
        end else begin
            state_q <= state_d;
            exmem_q <= exmem_d;
            case (state_q)
                S_IDLE: if (is_div) begin
                    dv_ctl   <= cur;
                    dv_op    <= bus.ex_ALUCtrl_in;
                    dv_rem   <= '0;
                    dv_quo   <= a_neg ? -op_a : op_a;
                    dv_dvs   <= b_neg ? -op_b : op_b;
                    dv_a     <= op_a;
                    dv_neg_q <= a_neg ^ b_neg;
                    dv_neg_r <= a_neg;
                    dv_zero  <= (op_b == '0);
                    dv_cnt   <= '0;
                end
                S_BUSY: begin
                    // Restoring step: keep the trial subtraction only if it did not borrow.
                    if (!diff[XLEN]) begin
                        dv_rem <= diff[XLEN-1:0];
                        dv_quo <= {dv_quo[XLEN-2:0], 1'b1};
                    end else begin
                        dv_rem <= rem_sh[XLEN-1:0];
                        dv_quo <= {dv_quo[XLEN-2:0], 1'b0};
                    end
                    dv_cnt <= dv_cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ex_busy_out           = busy;
    assign bus.mem_alu_result_out    = exmem_q.alu_result;
    assign bus.mem_write_data_out    = exmem_q.write_data;
    assign bus.mem_rd_addr_out       = exmem_q.rd;
    assign bus.mem_mem_read_out      = exmem_q.mem_read;
    assign bus.mem_mem_write_out     = exmem_q.mem_write;
    assign bus.mem_reg_write_out     = exmem_q.reg_write;
    assign bus.mem_MemToReg_out      = exmem_q.mem_to_reg;
    assign bus.mem_branch_taken_out  = exmem_q.br_taken;
    assign bus.mem_branch_target_out = exmem_q.br_target;
    assign bus.mem_instruction_out   = exmem_q.instr;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU and divide
// traffic checked against an arithmetic reference model.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_prev = '0;

    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    function automatic logic [31:0] div_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        sa = a; sb = b;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (op == 4'hB || op == 4'hD) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 0;
            end else begin
                q = sa / sb; r = sa % sb;
            end
        end else begin
            q = a / b; r = a % b;
        end
        return (op == 4'hB || op == 4'hC) ? q : r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        int unsigned sh;
        sa = a; sb = b; sh = b % 32;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: return sa >>> sh;
            4'h8: return (sa < sb) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return a * b;
            4'hF: return 32'd0;
            default: return div_ref(op, a, b);
        endcase
    endfunction

    task automatic idle_inputs();
        bus.ex_pc_plus_4_in   = '0;
        bus.ex_read_data1_in  = '0;
        bus.ex_read_data2_in  = '0;
        bus.ex_immediate_in   = '0;
        bus.ex_rd_addr_in     = '0;
        bus.ex_mem_read_in    = 1'b0;
        bus.ex_mem_write_in   = 1'b0;
        bus.ex_reg_write_in   = 1'b0;
        bus.ex_MemToReg_in    = 1'b0;
        bus.ex_ALUSrc_in      = 1'b0;
        bus.ex_Branch_in      = 1'b0;
        bus.ex_ALUCtrl_in     = 4'hF;
        bus.ex_instruction_in = 32'h13;
        bus.forward_a_sel     = 2'b00;
        bus.forward_b_sel     = 2'b00;
        bus.wb_write_data_in  = '0;
    endtask

    task automatic op_rr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        idle_inputs();
        bus.ex_ALUCtrl_in    = op;
        bus.ex_read_data1_in = a;
        bus.ex_read_data2_in = b;
        bus.ex_rd_addr_in    = rd;
        bus.ex_reg_write_in  = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.ex_busy_out !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", bus.ex_busy_out);
        end
        n_cmp++;
        if ({bus.mem_alu_result_out, bus.mem_write_data_out, bus.mem_rd_addr_out, bus.mem_mem_read_out,
             bus.mem_mem_write_out, bus.mem_reg_write_out, bus.mem_MemToReg_out, bus.mem_branch_taken_out,
             bus.mem_branch_target_out} !== '0) begin
            n_err++; $display("FAIL reset_mem: result %h rd %0d rw %b, want all zero",
                              bus.mem_alu_result_out, bus.mem_rd_addr_out, bus.mem_reg_write_out);
        end
        n_cmp++;
        if (bus.mem_instruction_out !== 32'h13) begin
            n_err++; $display("FAIL reset_instr: got %h want 00000013", bus.mem_instruction_out);
        end
        exp_prev = '0;
    endtask

    task automatic test_add_imm();
        op_rr(4'h0, 32'd5, 32'hDEAD_BEEF, 5'd3);
        bus.ex_ALUSrc_in    = 1'b1;
        bus.ex_immediate_in = 32'hFFFF_FFF9;
        tick();
        n_cmp++;
        if (bus.mem_alu_result_out !== 32'hFFFF_FFFE || bus.mem_rd_addr_out !== 5'd3 ||
            bus.mem_reg_write_out !== 1'b1) begin
            n_err++; $display("FAIL add_imm: res %h rd %0d rw %b, want fffffffe 3 1",
                              bus.mem_alu_result_out, bus.mem_rd_addr_out, bus.mem_reg_write_out);
        end
        n_cmp++;
        if (bus.mem_write_data_out !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL add_imm_store: got %h want deadbeef", bus.mem_write_data_out);
        end
        exp_prev = 32'hFFFF_FFFE;
    endtask

    task automatic test_forwarding();
        op_rr(4'h0, 32'h10, 32'h0, 5'd1);
        tick();
        op_rr(4'h1, 32'h5555_5555, 32'h3, 5'd2);
        bus.forward_a_sel = 2'b01;
        tick();
        n_cmp++;
        if (bus.mem_alu_result_out !== 32'h0D) begin
            n_err++; $display("FAIL fwd_a_mem: got %h want 0000000d", bus.mem_alu_result_out);
        end
        op_rr(4'h2, 32'h30, 32'h1234_5678, 5'd4);
        bus.forward_b_sel    = 2'b10;
        bus.wb_write_data_in = 32'h20;
        tick();
        n_cmp++;
        if (bus.mem_alu_result_out !== 32'h20 || bus.mem_write_data_out !== 32'h20) begin
            n_err++; $display("FAIL fwd_b_wb: res %h store %h want 00000020 00000020",
                              bus.mem_alu_result_out, bus.mem_write_data_out);
        end
        exp_prev = 32'h20;
    endtask

    task automatic test_branch();
        op_rr(4'h1, 32'd9, 32'd9, 5'd0);
        bus.ex_reg_write_in = 1'b0;
        bus.ex_Branch_in    = 1'b1;
        bus.ex_pc_plus_4_in = 32'h104;
        bus.ex_immediate_in = 32'h20;
        tick();
        n_cmp++;
        if (bus.mem_branch_taken_out !== 1'b1 || bus.mem_branch_target_out !== 32'h120) begin
            n_err++; $display("FAIL branch_eq: taken %b target %h want 1 00000120",
                              bus.mem_branch_taken_out, bus.mem_branch_target_out);
        end
        bus.ex_read_data2_in = 32'd8;
        tick();
        n_cmp++;
        if (bus.mem_branch_taken_out !== 1'b0) begin
            n_err++; $display("FAIL branch_ne: taken %b want 0", bus.mem_branch_taken_out);
        end
        exp_prev = 32'd1;
    endtask

    task automatic test_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit garbage, input string name);
        logic [31:0] exp, ins;
        logic [4:0]  rd;
        exp = div_ref(op, a, b);
        ins = $urandom;
        rd  = 5'($urandom_range(1, 31));
        op_rr(op, a, b, rd);
        bus.ex_instruction_in = ins;
        #1;
        n_cmp++;
        if (bus.ex_busy_out !== 1'b1) begin
            n_err++; $display("FAIL %s_busy_t0: got %b want 1", name, bus.ex_busy_out);
        end
        tick();
        for (int k = 1; k <= 33; k++) begin
            idle_inputs();
            if (garbage) begin
                op_rr(4'h0, $urandom, $urandom, 5'($urandom));
                bus.ex_instruction_in = $urandom;
            end
            #1;
            n_cmp++;
            if (bus.ex_busy_out !== (k <= 32) || bus.mem_reg_write_out !== 1'b0) begin
                n_err++; $display("FAIL %s_inflight: cycle t+%0d busy %b rw %b want %b 0",
                                  name, k, bus.ex_busy_out, bus.mem_reg_write_out, k <= 32);
            end
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (bus.mem_alu_result_out !== exp || bus.mem_reg_write_out !== 1'b1 ||
            bus.mem_rd_addr_out !== rd || bus.mem_instruction_out !== ins) begin
            n_err++; $display("FAIL %s_result: res %h rw %b rd %0d instr %h want %h 1 %0d %h",
                              name, bus.mem_alu_result_out, bus.mem_reg_write_out, bus.mem_rd_addr_out,
                              bus.mem_instruction_out, exp, rd, ins);
        end
        exp_prev = exp;
    endtask

    task automatic test_back_to_back();
        test_div(4'hC, 32'd100, 32'd7, 1'b0, "b2b_first");
        test_div(4'hE, 32'd100, 32'd7, 1'b0, "b2b_second");
    endtask

    task automatic test_random_alu();
        logic [3:0]  op;
        logic [31:0] a, bf, b, exp, tgt;
        logic [1:0]  fa, fb;
        logic        taken;
        for (int i = 0; i < 60; i++) begin
            idle_inputs();
            op = (i % 12 == 11) ? 4'hF : 4'($urandom_range(0, 10));
            bus.ex_ALUCtrl_in     = op;
            bus.ex_read_data1_in  = $urandom;
            bus.ex_read_data2_in  = (i % 5 == 0) ? bus.ex_read_data1_in : $urandom;
            bus.wb_write_data_in  = $urandom;
            bus.ex_immediate_in   = $urandom;
            bus.ex_pc_plus_4_in   = $urandom;
            bus.ex_ALUSrc_in      = 1'($urandom);
            bus.ex_Branch_in      = 1'($urandom);
            bus.ex_rd_addr_in     = 5'($urandom);
            bus.ex_reg_write_in   = 1'($urandom);
            bus.ex_mem_read_in    = 1'($urandom);
            bus.ex_mem_write_in   = 1'($urandom);
            bus.ex_MemToReg_in    = 1'($urandom);
            bus.ex_instruction_in = $urandom;
            fa = 2'($urandom); fb = 2'($urandom);
            bus.forward_a_sel = fa;
            bus.forward_b_sel = fb;
            a  = (fa == 2'b01) ? exp_prev : (fa == 2'b10) ? bus.wb_write_data_in : bus.ex_read_data1_in;
            bf = (fb == 2'b01) ? exp_prev : (fb == 2'b10) ? bus.wb_write_data_in : bus.ex_read_data2_in;
            b  = bus.ex_ALUSrc_in ? bus.ex_immediate_in : bf;
            exp   = alu_ref(op, a, b);
            taken = bus.ex_Branch_in && (a == bf);
            tgt   = bus.ex_pc_plus_4_in - 32'd4 + bus.ex_immediate_in;
            tick();
            n_cmp++;
            if (bus.mem_alu_result_out !== exp || bus.mem_write_data_out !== bf) begin
                n_err++; $display("FAIL rand_alu[%0d]: op %h res %h store %h want %h %h",
                                  i, op, bus.mem_alu_result_out, bus.mem_write_data_out, exp, bf);
            end
            n_cmp++;
            if (bus.mem_branch_taken_out !== taken || bus.mem_branch_target_out !== tgt ||
                bus.mem_rd_addr_out !== bus.ex_rd_addr_in || bus.mem_reg_write_out !== bus.ex_reg_write_in ||
                bus.mem_mem_read_out !== bus.ex_mem_read_in || bus.mem_mem_write_out !== bus.ex_mem_write_in ||
                bus.mem_MemToReg_out !== bus.ex_MemToReg_in || bus.mem_instruction_out !== bus.ex_instruction_in) begin
                n_err++; $display("FAIL rand_ctl[%0d]: taken %b tgt %h rd %0d rw %b want %b %h %0d %b",
                                  i, bus.mem_branch_taken_out, bus.mem_branch_target_out, bus.mem_rd_addr_out,
                                  bus.mem_reg_write_out, taken, tgt, bus.ex_rd_addr_in, bus.ex_reg_write_in);
            end
            exp_prev = exp;
        end
        idle_inputs();
    endtask

    task automatic test_random_div();
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 5) ? 32'd0 : ((i % 2 == 1) ? ($urandom >> $urandom_range(0, 28)) : $urandom);
            test_div(4'($urandom_range(11, 14)), a, b, i[0], "rand_div");
        end
    endtask

    task automatic test_reset_mid_div();
        op_rr(4'hB, 32'd1000, 32'd3, 5'd7);
        tick();
        idle_inputs();
        for (int k = 1; k < 11; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.ex_busy_out !== 1'b0 || bus.mem_reg_write_out !== 1'b0 || bus.mem_alu_result_out !== '0 ||
            bus.mem_rd_addr_out !== '0 || bus.mem_instruction_out !== 32'h13) begin
            n_err++; $display("FAIL reset_mid_div: busy %b rw %b res %h rd %0d instr %h want 0 0 0 0 00000013",
                              bus.ex_busy_out, bus.mem_reg_write_out, bus.mem_alu_result_out,
                              bus.mem_rd_addr_out, bus.mem_instruction_out);
        end
        op_rr(4'h0, 32'd1, 32'd2, 5'd9);
        tick();
        n_cmp++;
        if (bus.mem_alu_result_out !== 32'd3 || bus.mem_reg_write_out !== 1'b1 || bus.mem_rd_addr_out !== 5'd9) begin
            n_err++; $display("FAIL add_after_reset: res %h rw %b rd %0d want 3 1 9",
                              bus.mem_alu_result_out, bus.mem_reg_write_out, bus.mem_rd_addr_out);
        end
        idle_inputs();
        tick();
        exp_prev = '0;
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_forwarding();
        test_branch();
        test_div(4'hB, 32'hFFFF_FFEC, 32'd3, 1'b0, "div_neg");
        test_div(4'hD, 32'd7, 32'd0, 1'b1, "rem_zero");
        test_div(4'hB, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        test_div(4'hB, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_zero_neg");
        test_back_to_back();
        test_random_alu();
        test_random_div();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
